// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: video scan-out reads, whole-RAM clear fill and CPU accesses
// share one synchronous RAM port with fixed priority video > clear > CPU.
module vram_arbiter #(
    parameter int unsigned A = 14,
    parameter int unsigned D = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         vid_req,
    input  logic [A-1:0] vid_addr,
    output logic         vid_valid,
    output logic [D-1:0] vid_rdata,
    input  logic         cpu_req,
    input  logic         cpu_we,
    input  logic [A-1:0] cpu_addr,
    input  logic [D-1:0] cpu_wdata,
    output logic         cpu_ack,
    output logic [D-1:0] cpu_rdata,
    input  logic         clr_start,
    input  logic [D-1:0] clr_value,
    output logic         clr_busy,
    output logic [A-1:0] ram_addr,
    output logic [D-1:0] ram_din,
    output logic         ram_we,
    input  logic [D-1:0] ram_dout
);

    typedef enum logic [1:0] {StIdle, StCpuAck, StClear} state_e;

    localparam logic [A-1:0] CntMax = '1;

    state_e         state_q;
    logic           clr_pend_q;
    logic [A-1:0]   cnt_q;
    logic [D-1:0]   clr_val_q;
    logic           vid_valid_q;
    logic           cpu_rd_q;
    logic [D-1:0]   cpu_rdata_q;

    logic clr_now;
    logic vid_grant;
    logic clr_grant;
    logic cpu_grant;

    // A clr_start arriving this cycle already outranks a coincident cpu_req.
    assign clr_now   = clr_pend_q | clr_start;
    assign vid_grant = reset & vid_req;
    assign clr_grant = reset & ~vid_req & (state_q == StClear);
    assign cpu_grant = reset & ~vid_req & (state_q == StIdle) & ~clr_now & cpu_req;

    always_comb begin
        ram_addr = '0;
        ram_din  = '0;
        ram_we   = 1'b0;
        if (vid_grant) begin
            ram_addr = vid_addr;
        end else if (clr_grant) begin
            ram_addr = cnt_q;
            ram_din  = clr_val_q;
            ram_we   = 1'b1;
        end else if (cpu_grant) begin
            ram_addr = cpu_addr;
            ram_din  = cpu_wdata;
            ram_we   = cpu_we;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            clr_pend_q  <= 1'b0;
            cnt_q       <= '0;
            clr_val_q   <= '0;
            vid_valid_q <= 1'b0;
            cpu_rd_q    <= 1'b0;
            cpu_rdata_q <= '0;
        end else begin
            vid_valid_q <= vid_req;
            unique case (state_q)
                StIdle: begin
                    if (clr_start) begin
                        clr_val_q <= clr_value;
                    end
                    if (!vid_req && clr_now) begin
                        state_q    <= StClear;
                        cnt_q      <= '0;
                        clr_pend_q <= 1'b0;
                    end else if (!vid_req && cpu_req) begin
                        state_q  <= StCpuAck;
                        cpu_rd_q <= ~cpu_we;
                    end else if (clr_start) begin
                        clr_pend_q <= 1'b1;
                    end
                end
                StCpuAck: begin
                    if (clr_start) begin
                        clr_pend_q <= 1'b1;
                        clr_val_q  <= clr_value;
                    end
                    if (cpu_rd_q) begin
                        cpu_rdata_q <= ram_dout;
                    end
                    state_q <= StIdle;
                end
                StClear: begin
                    // Video cycles steal the port; the fill simply pauses.
                    if (!vid_req) begin
                        if (cnt_q == CntMax) begin
                            state_q <= StIdle;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign vid_valid = vid_valid_q;
    assign vid_rdata = vid_valid_q ? ram_dout : '0;
    assign cpu_ack   = (state_q == StCpuAck);
    assign cpu_rdata = (cpu_ack && cpu_rd_q) ? ram_dout : cpu_rdata_q;
    assign clr_busy  = clr_pend_q | (state_q == StClear);

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: randomized traffic against a per-cycle reference of the
// arbitration rules, with a behavioural synchronous RAM attached to the RAM port.
module tb_vram_arbiter;
    localparam int unsigned A = 9;
    localparam int unsigned D = 8;
    localparam int unsigned N = 1 << A;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         vid_req = 1'b0;
    logic [A-1:0] vid_addr = '0;
    logic         vid_valid;
    logic [D-1:0] vid_rdata;
    logic         cpu_req = 1'b0;
    logic         cpu_we = 1'b0;
    logic [A-1:0] cpu_addr = '0;
    logic [D-1:0] cpu_wdata = '0;
    logic         cpu_ack;
    logic [D-1:0] cpu_rdata;
    logic         clr_start = 1'b0;
    logic [D-1:0] clr_value = '0;
    logic         clr_busy;
    logic [A-1:0] ram_addr;
    logic [D-1:0] ram_din;
    logic         ram_we;
    logic [D-1:0] ram_dout;

    always #5 clk = ~clk;

    vram_arbiter #(.A(A), .D(D)) dut (
        .clk       (clk),
        .reset     (reset),
        .vid_req   (vid_req),
        .vid_addr  (vid_addr),
        .vid_valid (vid_valid),
        .vid_rdata (vid_rdata),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .clr_start (clr_start),
        .clr_value (clr_value),
        .clr_busy  (clr_busy),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_we    (ram_we),
        .ram_dout  (ram_dout)
    );

    // Behavioural RAM_sync: registered read, one cycle of latency.
    logic [D-1:0] ram [N];
    always @(posedge clk) begin
        if (ram_we) ram[ram_addr] <= ram_din;
        ram_dout <= ram[ram_addr];
    end

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Reference state: what the RAM should hold and where the arbitration stands.
    logic [D-1:0] ref_mem [N];
    bit           m_pend = 0;
    bit           m_clearing = 0;
    int           m_idx = 0;
    logic [D-1:0] m_val = '0;
    bit           m_ack_due = 0;
    bit           m_vid_prev = 0;
    logic [D-1:0] m_rdata = '0;
    logic [D-1:0] vq[$];
    logic [D-1:0] cq[$];

    bit           cpu_active = 0;
    logic         c_we = 1'b0;
    logic [A-1:0] c_addr = '0;
    logic [D-1:0] c_wdata = '0;

    bit           chk_en = 0;
    logic         exp_vvalid, exp_ack, exp_busy, exp_we;
    logic [A-1:0] exp_waddr;
    logic [D-1:0] exp_wdata;

    int busy_cnt = 0, busy_vid = 0, wr_cnt = 0, ack_cyc = 0, wr_at_ack = 0;
    logic ack_busy = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic cpu_start(input logic we, input logic [A-1:0] a, input logic [D-1:0] d);
        c_we = we;
        c_addr = a;
        c_wdata = d;
        cpu_active = 1;
    endtask

    task automatic model_reset();
        m_pend = 0; m_clearing = 0; m_idx = 0; m_ack_due = 0; m_vid_prev = 0;
        m_rdata = '0; cpu_active = 0;
        vq.delete();
        cq.delete();
    endtask

    // One clock cycle: drive inputs, derive this cycle's expected outputs, advance the reference.
    task automatic step(input bit vid, input logic [A-1:0] va, input bit clr,
                        input logic [D-1:0] cv);
        @(posedge clk);
        #1;
        cyc++;
        if (m_ack_due) cpu_active = 0;
        vid_req = vid; vid_addr = va; clr_start = clr; clr_value = cv;
        cpu_req = cpu_active; cpu_we = c_we; cpu_addr = c_addr; cpu_wdata = c_wdata;

        exp_vvalid = m_vid_prev;
        exp_ack = m_ack_due;
        exp_busy = m_pend | m_clearing;
        exp_we = 1'b0; exp_waddr = '0; exp_wdata = '0;

        if (vid) vq.push_back(ref_mem[va]);
        if (m_ack_due) begin
            m_ack_due = 0;
            if (clr) begin m_pend = 1; m_val = cv; end
        end else if (m_clearing) begin
            if (!vid) begin
                exp_we = 1'b1; exp_waddr = A'(m_idx); exp_wdata = m_val;
                ref_mem[m_idx] = m_val;
                if (m_idx == int'(N) - 1) m_clearing = 0;
                else m_idx++;
            end
        end else begin
            if (clr) begin m_pend = 1; m_val = cv; end
            if (!vid) begin
                if (m_pend) begin
                    m_clearing = 1; m_idx = 0; m_pend = 0;
                end else if (cpu_active) begin
                    if (c_we) begin
                        exp_we = 1'b1; exp_waddr = c_addr; exp_wdata = c_wdata;
                        ref_mem[c_addr] = c_wdata;
                    end else begin
                        m_rdata = ref_mem[c_addr];
                    end
                    cq.push_back(m_rdata);
                    m_ack_due = 1;
                end
            end
        end
        m_vid_prev = vid;
        chk_en = 1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, 0, '0);
    endtask

    task automatic run_cpu_done(input int limit);
        for (int i = 0; i < limit && cpu_active; i++) step(0, '0, 0, '0);
        step(0, '0, 0, '0);
        chk("cpu_timeout", 32'(cpu_active), 0);
    endtask

    // Fill with cv while video reads already-written addresses every 4th cycle.
    task automatic do_clear(input logic [D-1:0] cv);
        step(0, '0, 1, cv);
        for (int i = 0; i < 1200 && (m_clearing || m_pend); i++) begin
            if (i % 4 == 2 && m_idx > 0) step(1, A'($urandom_range(0, m_idx - 1)), 0, '0);
            else step(0, '0, 0, '0);
        end
        idle(2);
    endtask

    function automatic logic [A-1:0] rand_addr();
        if ($urandom_range(0, 1) == 0) return A'($urandom_range(0, 15));
        return A'(N - 1 - $urandom_range(0, 3));
    endfunction

    // Monitor: pops the scoreboard when the DUT presents data, and checks the RAM port.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("vid_valid", 32'(vid_valid), 32'(exp_vvalid));
            if (vid_valid) begin
                chk("vid_queue_nonempty", 32'(vq.size() != 0), 1);
                if (vq.size() != 0) chk("vid_rdata", 32'(vid_rdata), 32'(vq.pop_front()));
            end
            chk("cpu_ack", 32'(cpu_ack), 32'(exp_ack));
            if (cpu_ack) begin
                ack_cyc = cyc; ack_busy = clr_busy; wr_at_ack = wr_cnt;
                chk("cpu_queue_nonempty", 32'(cq.size() != 0), 1);
                if (cq.size() != 0) chk("cpu_rdata", 32'(cpu_rdata), 32'(cq.pop_front()));
            end
            chk("clr_busy", 32'(clr_busy), 32'(exp_busy));
            chk("ram_we", 32'(ram_we), 32'(exp_we));
            if (exp_we) begin
                chk("ram_addr", 32'(ram_addr), 32'(exp_waddr));
                chk("ram_din", 32'(ram_din), 32'(exp_wdata));
            end
            if (vid_req) chk("no_write_in_vid", 32'(ram_we), 0);
            if (ram_we) wr_cnt++;
            if (clr_busy) begin
                busy_cnt++;
                if (vid_req) busy_vid++;
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_vid_valid"}, 32'(vid_valid), 0);
        chk({tag, "_vid_rdata"}, 32'(vid_rdata), 0);
        chk({tag, "_cpu_ack"}, 32'(cpu_ack), 0);
        chk({tag, "_cpu_rdata"}, 32'(cpu_rdata), 0);
        chk({tag, "_clr_busy"}, 32'(clr_busy), 0);
        chk({tag, "_ram_we"}, 32'(ram_we), 0);
        chk({tag, "_ram_addr"}, 32'(ram_addr), 0);
        chk({tag, "_ram_din"}, 32'(ram_din), 0);
    endtask

    initial begin
        int last_vid;
        for (int i = 0; i < int'(N); i++) ref_mem[i] = '0;
        vid_req = 1'b1; vid_addr = A'(9'h055);
        @(negedge clk);
        chk_all_zero("reset");
        vid_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        // Clear with value 0 and periodic video: 512 in-order writes, busy = 512 + video cycles.
        busy_cnt = 0; busy_vid = 0; wr_cnt = 0;
        do_clear(8'h00);
        chk("clear_writes", 32'(wr_cnt), N);
        chk("clear_busy_len", 32'(busy_cnt), 32'(N + busy_vid));

        // Video read of a CPU-written location, then CPU write/read of 0x100.
        cpu_start(1, A'(9'h041), 8'h07);
        run_cpu_done(10);
        step(1, A'(9'h041), 0, '0);
        idle(2);
        cpu_start(1, A'(9'h100), 8'h5A);
        run_cpu_done(10);
        cpu_start(0, A'(9'h100), '0);
        run_cpu_done(10);

        // CPU held off by five video cycles, then acked two cycles after the last one.
        cpu_start(1, A'(9'h0AA), 8'h33);
        for (int i = 0; i < 5; i++) step(1, rand_addr(), 0, '0);
        last_vid = cyc;
        run_cpu_done(10);
        chk("cpu_lat_after_vid", 32'(ack_cyc), 32'(last_vid + 2));

        // Coincident clr_start and cpu_req: the whole clear precedes the CPU ack.
        wr_cnt = 0;
        cpu_start(1, A'(9'h123), 8'h99);
        step(0, '0, 1, 8'h3C);
        run_cpu_done(700);
        chk("clear_before_cpu_writes", 32'(wr_at_ack), N + 1);
        chk("clear_before_cpu_busy", 32'(ack_busy), 0);
        step(1, A'(9'h123), 0, '0);
        step(1, A'(9'h124), 0, '0);
        idle(2);

        // Randomized mixed traffic.
        for (int i = 0; i < 3000; i++) begin
            if (!cpu_active && $urandom_range(0, 2) == 0)
                cpu_start($urandom_range(0, 1) == 1, rand_addr(), D'($urandom));
            step($urandom_range(0, 2) == 0, rand_addr(), $urandom_range(0, 399) == 0,
                 D'($urandom));
        end
        run_cpu_done(700);
        for (int i = 0; i < 700 && (m_clearing || m_pend); i++) step(0, '0, 0, '0);
        idle(2);
        chk("vid_queue_drained", 32'(vq.size()), 0);
        chk("cpu_queue_drained", 32'(cq.size()), 0);

        // Reset while the clear counter sits at 7.
        step(0, '0, 1, 8'hA5);
        for (int i = 0; i < 20 && !(m_clearing && m_idx == 7); i++) step(0, '0, 0, '0);
        chk("reached_cnt7", 32'(m_clearing && m_idx == 7), 1);
        @(posedge clk);
        #2;
        chk_en = 0;
        vid_req = 1'b1; vid_addr = A'(9'h055); cpu_req = 1'b1; cpu_we = 1'b1;
        reset = 1'b0;
        #1;
        chk_all_zero("midclr_reset");
        repeat (2) @(negedge clk);
        chk_all_zero("held_reset");
        vid_req = 1'b0; cpu_req = 1'b0;
        reset = 1'b1;
        model_reset();
        idle(3);
        wr_cnt = 0; busy_cnt = 0; busy_vid = 0;
        do_clear(8'hC3);
        chk("reclear_writes", 32'(wr_cnt), N);
        cpu_start(0, A'(9'h010), '0);
        run_cpu_done(10);
        step(1, A'(9'h1FF), 0, '0);
        idle(2);
        chk("final_vid_queue", 32'(vq.size()), 0);
        chk("final_cpu_queue", 32'(cq.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
